// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one operation at a time,
// 32 iterations per multiply (shift-add) or divide (restoring), stalls the pipeline meanwhile.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [4:0]      LAST_BIT = 5'(XLEN-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [4:0]      r_count;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_result;

  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_sign;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic            w_load;
  logic            w_finish;
  logic            w_ge;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_addend;
  logic [XLEN-1:0] w_lo_nx;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN:0]   w_hi_nx;

  // Products are negated as a whole 64-bit value before the half is picked.
  function automatic logic [XLEN-1:0] f_fix_result(
    input logic [2:0]      op,
    input logic            neg,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qr;
    if (!op[2]) begin
      prod = {hi, lo};
      if (neg) prod = -prod;
      return (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    qr = op[1] ? hi : lo;
    return neg ? -qr : qr;
  endfunction

  assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & a[XLEN-1];
  assign w_b_neg    = w_b_signed & b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  // Remainder takes only the dividend sign; everything else takes the XOR.
  assign w_sign     = w_a_neg ^ (w_b_neg & ~(funct3[2] & funct3[1]));

  assign w_div0    = funct3[2] & (b == '0);
  assign w_ovf     = funct3[2] & ~funct3[0] & (a == MIN_NEG) & (b == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = funct3[1] ? a : '1;
    else if (w_ovf) w_special_res = funct3[1] ? '0 : MIN_NEG;
  end

  assign w_addend = r_lo[0] ? r_opb : '0;
  assign w_sum    = r_hi + {1'b0, w_addend};
  assign w_shift  = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_opb};
  assign w_ge     = w_shift >= {1'b0, r_opb};

  always_comb begin
    if (r_op[2]) begin
      w_hi_nx = w_ge ? w_diff : w_shift;
      w_lo_nx = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nx = {1'b0, w_sum[XLEN:1]};
      w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_load   = (r_state == IDLE) & start & ~flush;
  assign w_finish = (r_state == BUSY) & (r_count == 5'd0) & ~flush;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nx = w_special ? DONE : BUSY;
      BUSY:    if (r_count == 5'd0) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (flush) w_state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= 5'd0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load && !w_special) r_count <= LAST_BIT;
      else if (r_state == BUSY && r_count != 5'd0) r_count <= r_count - 5'd1;
      if (w_load && w_special) r_result <= w_special_res;
      else if (w_finish) r_result <= f_fix_result(r_op, r_neg, w_hi_nx[XLEN-1:0], w_lo_nx);
    end
  end

  // Datapath: multiply keeps multiplier in r_lo, divide shifts dividend out of r_lo.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_op  <= funct3;
      r_neg <= w_sign;
      r_hi  <= '0;
      r_lo  <= funct3[2] ? w_a_mag : w_b_mag;
      r_opb <= funct3[2] ? w_b_mag : w_a_mag;
    end else if (r_state == BUSY) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
    end
  end

  assign stall  = ~rst & (w_load | (r_state == BUSY));
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: expected result and latency queued at issue,
// checked when done pulses.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];

  rv32m_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    logic signed [31:0] qx, qy, sq;
    logic               ovf;
    logic [31:0]        r;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    qx  = x;
    qy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r   = 32'd0;
    p   = 64'sd0;
    case (f)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin sq = qx / qy; r = sq; end
      end
      3'd5: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) r = x;
        else if (ovf) r = 32'd0;
        else begin sq = qx % qy; r = sq; end
      end
      default: r = (y == 32'd0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that ends the DONE cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input int nst);
    int st;
    bit got;
    st  = 0;
    got = 1'b0;
    sb.push_back('{exp, cyc, lat});
    funct3 = f3;
    a      = x;
    b      = y;
    start  = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (stall === 1'b1) st++;
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) chk("timeout", 32'd0, 32'd1);
    chk("stall_cycles", 32'(st), 32'(nst));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] rx, ry, rexp;
    int          rlat;
    bit          spec;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    #1;
    chk("stall_in_reset", 32'(stall), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", result, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 33);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 33);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 33);
    run_op(3'd5, 32'd7, 32'd2, 32'd3, 33, 33);
    run_op(3'd7, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 33, 33);

    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("result_hold", result, 32'd5);

    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
      rexp = ref_op(rf, rx, ry);
      spec = rf[2] && ((ry == 32'd0) ||
             (!rf[0] && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF));
      rlat = spec ? 1 : 33;
      run_op(rf, rx, ry, rexp, rlat, rlat);
    end

    funct3 = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 33);

    funct3 = 3'd4; a = 32'd1000; b = 32'hFFFF_FFFD; start = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("stall_forced_low", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("midop_reset_result", result, 32'd0);
    chk("midop_reset_done", 32'(done), 32'd0);
    chk("midop_reset_stall", 32'(stall), 32'd0);
    run_op(3'd3, 32'd2, 32'd3, 32'd0, 33, 33);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
# rv32m_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. It accepts one M-extension operation from the EX stage registers and stalls the pipeline while it iterates. It then presents a registered 32-bit result for one cycle, which the EX/MEM register captures as the ALU-out value consumed by the regfile write mux. It executes one operation at a time; there is no internal queueing.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a valid M-extension instruction; held high by the stalled pipeline until done.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 value (post-forwarding).
- b  in  XLEN  rs2 value (post-forwarding).
- flush  in  1  branch/jump flush of EX; aborts the operation in progress.
- stall  out  1  freeze PC, IF/ID, ID/EX; combinational.
- done  out  1  one-cycle pulse: result valid, pipeline advances this cycle.
- result  out  XLEN  registered result, valid while done=1.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY when start=1 and flush=0.
  - Latches funct3 and the operand magnitudes (absolute value for signed operands: a for MUL*/DIV/REM except MULHU; b for MULH/DIV/REM).
  - Latches the result sign and loads count=31.
- IDLE -> DONE directly for the special cases below; result is loaded in the same edge.
  - Divide by zero (b=0, funct3[2]=1): DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- BUSY, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- BUSY, divide: restoring division, one quotient bit per cycle, 32-bit remainder plus one guard bit.
- BUSY: count decrements each cycle. At count=0 go to DONE and register the sign-corrected result:
  - MUL: low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU: high 32 bits of the 64-bit product. Negation is applied over the full 64 bits before selection.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- DONE -> IDLE unconditionally. The same instruction leaves EX at the end of DONE. start seen in the next IDLE cycle is a new instruction.
- stall = (state==IDLE & start & ~flush) | (state==BUSY). It is 0 in DONE.
- flush in any state: next state IDLE, done stays 0, result unchanged. flush has priority over start and over completion.
- rst: state IDLE, count 0, result 0x00000000, done 0. stall is forced 0 while rst=1.
- start deasserting while BUSY (illegal for the pipeline) is ignored; the operation completes.

## Timing
- Normal op: start sampled in cycle 0 (stall=1). BUSY occupies cycles 1-32 (stall=1). DONE is cycle 33 (done=1, stall=0).
- Total: 34 cycles in EX, 33 stall cycles.
- Special case: start in cycle 0 (stall=1), DONE in cycle 1 (done=1). 1 stall cycle.
- result changes only on entry to DONE. It holds its value after DONE until the next completion.
- done is never high for two consecutive cycles.
- Back-to-back ops: the second start is accepted in the cycle after DONE.
- flush in cycle k: the unit is IDLE in cycle k+1 and can accept start in k+1.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3): stall high in cycles 0-32, done in cycle 33, result 0xFFFFFFEB.
- High products: MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. Each op has done at cycle 33.
- Division signs: DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 7/2 -> 3. REMU 0xFFFFFFFF/16 -> 0xF. Run back-to-back with no idle gap.
- Special cases: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same operands -> 0. Each has done in cycle 1 and exactly 1 stall cycle.
- Flush: MUL 3x4 started, flush in cycle 10 -> done never pulses and stall=0 in cycle 11. DIVU 100/7 started in cycle 11 -> done at cycle 44, result 14.
- Reset: rst asserted in cycle 15 of a DIV -> cycle 16 has state IDLE, result 0, done 0, stall 0. A following MULHU 2x3 -> 0 at 33 cycles after its start.
